// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one shared full adder walks the operands LSB first
// over WIDTH cycles, then presents Y/CO/OVF with a one-cycle DONE pulse.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVF
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic a_bit, b_bit;
  logic ha0_s, ha0_c, ha1_c;
  logic sum_bit, cout;
  logic last_bit;

  // Shared 1-bit full adder: two half adders plus OR; subtract inverts B.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0] ^ op_q;
    ha0_s    = a_bit ^ b_bit;
    ha0_c    = a_bit & b_bit;
    sum_bit  = ha0_s ^ carry_q;
    ha1_c    = ha0_s & carry_q;
    cout     = ha0_c | ha1_c;
    last_bit = (count_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    count_d = count_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          count_d = '0;
          carry_d = OP;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = WIDTH'({sum_bit, acc_q} >> 1);
        carry_d = cout;
        count_d = count_q + CW'(1);
        if (last_bit) begin
          state_d = S_DONE;
          y_d     = WIDTH'({sum_bit, acc_q} >> 1);
          co_d    = cout;
          ovf_d   = carry_q ^ cout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      count_q <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      count_q <= count_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Y    = y_q;
  assign CO   = co_q;
  assign OVF  = ovf_q;

endmodule
